// File: rtl/core_dbus_arbiter_if.sv
// ----------------------------------------------------------------------------
// core_dbus_arbiter_if
// One peripheral data-bus channel: request (addr/wdata/store_type/valid)
// travelling from a requester to a responder, and the response
// (rdata/ready) travelling back.
//
// Modports
//   master : the requester side. It drives the request and receives the response.
//   slave  : the responder side. It receives the request and drives the response.
//
// Signals
//   addr        64       request address
//   wdata       64       request write data
//   store_type  ST_W     store type (nonzero = store, zero = load)
//   valid       1        request valid; the requester holds it until ready or abandon
//   rdata       64       response read data, meaningful while ready=1
//   ready       1        completion pulse
// ----------------------------------------------------------------------------
interface core_dbus_arbiter_if #(
    parameter int ST_W = 3
);
    typedef logic [ST_W-1:0] mem_store_type_t;

    logic [63:0]     addr;
    logic [63:0]     wdata;
    mem_store_type_t store_type;
    logic            valid;
    logic [63:0]     rdata;
    logic            ready;

    modport master (
        output addr,
        output wdata,
        output store_type,
        output valid,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        input  wdata,
        input  store_type,
        input  valid,
        output rdata,
        output ready
    );
endinterface

// File: rtl/core_dbus_arbiter.sv
// ----------------------------------------------------------------------------
// core_dbus_arbiter
// Shares one peripheral data bus between two masters. m0 is the core
// MEM-stage data port and m1 is a secondary master such as debug or DMA.
// Arbitration is round-robin. The winner keeps the bus until its transaction
// completes, times out, or is abandoned. A watchdog ends a hung slave
// transaction with an error response.
//
// Ports
//   clock        in   system clock; all state changes on the rising edge
//   reset        in   synchronous, active-high
//   m0, m1       slave modport of core_dbus_arbiter_if (the masters' requests)
//   s            master modport of core_dbus_arbiter_if (the shared slave bus)
//   grant        out  index of the master owning the bus (meaningful while busy)
//   busy         out  1 while a transaction owns the bus
//   timeout_err  out  one-cycle pulse when the watchdog forces a completion
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles without s.ready before a forced completion; 0 disables
//   TO_W            watchdog counter width; must be wide enough for TIMEOUT_CYCLES
//   ST_W            store-type width; must match the interface instances
// ----------------------------------------------------------------------------
module core_dbus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8,
    parameter int ST_W           = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    core_dbus_arbiter_if.slave      m0,
    core_dbus_arbiter_if.slave      m1,
    core_dbus_arbiter_if.master     s,
    output logic                    grant,
    output logic                    busy,
    output logic                    timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic            WDOG_EN   = (TIMEOUT_CYCLES != 0);
    // Last BUSY cycle the watchdog tolerates. When the watchdog is disabled this
    // value is never used, because WDOG_EN gates every use of it.
    localparam logic [TO_W-1:0] WDOG_LAST = WDOG_EN ? TO_W'(TIMEOUT_CYCLES - 1) : {TO_W{1'b0}};
    localparam logic [63:0]     ERR_DATA  = 64'hDEAD_DEAD_DEAD_DEAD;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q,  last_d;
    logic [TO_W-1:0] wdog_q,  wdog_d;

    // Request fields of whichever master currently holds the grant
    logic            g_valid_s;
    logic [63:0]     g_addr_s;
    logic [63:0]     g_wdata_s;
    logic [ST_W-1:0] g_store_s;

    // Response before it is steered to the granted master
    logic            rsp_ready_s;
    logic [63:0]     rsp_rdata_s;
    logic            done_s;
    logic            tout_s;

    // Select the granted master's request fields
    always_comb begin
        if (grant_q) begin
            g_valid_s = m1.valid;
            g_addr_s  = m1.addr;
            g_wdata_s = m1.wdata;
            g_store_s = m1.store_type;
        end else begin
            g_valid_s = m0.valid;
            g_addr_s  = m0.addr;
            g_wdata_s = m0.wdata;
            g_store_s = m0.store_type;
        end
    end

    // Next-state logic, slave-side request and completion/timeout detection
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        wdog_d       = wdog_q;
        s.addr       = 64'h0;
        s.wdata      = 64'h0;
        s.store_type = {ST_W{1'b0}};
        s.valid      = 1'b0;
        rsp_ready_s  = 1'b0;
        rsp_rdata_s  = 64'h0;
        done_s       = 1'b0;
        tout_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // s.ready is deliberately ignored here. The grant is taken now
                // and the bus is driven from the next cycle, so a request in
                // cycle N reaches s.valid no earlier than N+1.
                wdog_d = {TO_W{1'b0}};
                if (m0.valid && m1.valid) begin
                    grant_d = ~last_q;
                    state_d = ST_BUSY;
                end else if (m0.valid) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (m1.valid) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                s.addr  = g_addr_s;
                s.wdata = g_wdata_s;
                s.valid = g_valid_s;
                // Only forward the store type with a live request, so the
                // slave never sees a store without a request.
                s.store_type = g_valid_s ? g_store_s : {ST_W{1'b0}};

                done_s = g_valid_s && s.ready;
                // A real s.ready in the final watchdog cycle takes priority
                // over the timeout.
                tout_s = WDOG_EN && g_valid_s && !s.ready && (wdog_q == WDOG_LAST);

                if (done_s) begin
                    rsp_ready_s = 1'b1;
                    rsp_rdata_s = s.rdata;
                end else if (tout_s) begin
                    rsp_ready_s = 1'b1;
                    rsp_rdata_s = ERR_DATA;
                end else begin
                    rsp_ready_s = 1'b0;
                end

                // Completion, timeout and abandon all release the bus. Recording
                // the finishing master as last hands any tie to the other one.
                if (!g_valid_s || done_s || tout_s) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                    wdog_d  = {TO_W{1'b0}};
                end else if (WDOG_EN) begin
                    wdog_d = wdog_q + TO_W'(1);
                end else begin
                    wdog_d = {TO_W{1'b0}};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Steer the response to the granted master; the other master sees zeros
    always_comb begin
        m0.ready = 1'b0;
        m0.rdata = 64'h0;
        m1.ready = 1'b0;
        m1.rdata = 64'h0;
        if (grant_q) begin
            m1.ready = rsp_ready_s;
            m1.rdata = rsp_rdata_s;
        end else begin
            m0.ready = rsp_ready_s;
            m0.rdata = rsp_rdata_s;
        end
    end

    // Status outputs
    always_comb begin
        busy        = (state_q == ST_BUSY);
        grant       = grant_q;
        timeout_err = tout_s;
    end

    // State register. Reset drops any outstanding transaction, and m0 wins
    // the first tie after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= {TO_W{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_core_dbus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_core_dbus_arbiter
// Bench for core_dbus_arbiter, built with TIMEOUT_CYCLES=4.
// A transaction-level reference model tracks who owns the bus, who finished
// last, and how long the current transaction has been open. Every cycle on
// the falling edge it derives the expected outputs from the live inputs and
// compares them with the DUT. Directed scenarios also pin literal values.
// ----------------------------------------------------------------------------
module tb_core_dbus_arbiter;

    localparam int          T    = 4;
    localparam logic [63:0] DEAD = 64'hDEAD_DEAD_DEAD_DEAD;

    logic clock;
    logic reset;
    logic grant;
    logic busy;
    logic timeout_err;

    core_dbus_arbiter_if #(.ST_W(3)) i_m0 ();
    core_dbus_arbiter_if #(.ST_W(3)) i_m1 ();
    core_dbus_arbiter_if #(.ST_W(3)) i_s  ();

    core_dbus_arbiter #(
        .TIMEOUT_CYCLES (T),
        .TO_W           (8),
        .ST_W           (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .m0          (i_m0),
        .m1          (i_m1),
        .s           (i_s),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mdl_busy  = 1'b0;
    int          mdl_owner = 0;
    int          mdl_last  = 1;
    int          mdl_age   = 0;

    logic        mv  [2];
    logic [63:0] ma  [2];
    logic [63:0] mw  [2];
    logic [2:0]  mst [2];
    logic        e_sv;
    logic [63:0] e_sa;
    logic [63:0] e_sw;
    logic [2:0]  e_sst;
    logic        e_rdy [2];
    logic [63:0] e_rd  [2];
    logic        e_to;
    bit          fin;
    int          g;

    always @(negedge clock) begin
        if (mon_en) begin
            mv[0] = i_m0.valid;  ma[0] = i_m0.addr;  mw[0] = i_m0.wdata;  mst[0] = i_m0.store_type;
            mv[1] = i_m1.valid;  ma[1] = i_m1.addr;  mw[1] = i_m1.wdata;  mst[1] = i_m1.store_type;
            e_sv = 1'b0; e_sa = 64'h0; e_sw = 64'h0; e_sst = 3'd0; e_to = 1'b0;
            e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = 64'h0; e_rd[1] = 64'h0;
            fin = 1'b0;
            g = mdl_owner;
            if (mdl_busy) begin
                e_sv  = mv[g];
                e_sa  = ma[g];
                e_sw  = mw[g];
                e_sst = mv[g] ? mst[g] : 3'd0;
                if (mv[g] && i_s.ready) begin
                    e_rdy[g] = 1'b1; e_rd[g] = i_s.rdata; fin = 1'b1;
                end else if (mv[g] && mdl_age == T - 1) begin
                    e_rdy[g] = 1'b1; e_rd[g] = DEAD; e_to = 1'b1; fin = 1'b1;
                end else if (!mv[g]) begin
                    fin = 1'b1;
                end
            end
            chk("busy", {63'h0, busy}, {63'h0, mdl_busy});
            if (mdl_busy) chk("grant", {63'h0, grant}, 64'(mdl_owner));
            chk("s_valid",     {63'h0, i_s.valid},   {63'h0, e_sv});
            chk("s_addr",      i_s.addr,             e_sa);
            chk("s_wdata",     i_s.wdata,            e_sw);
            chk("s_store",     {61'h0, i_s.store_type}, {61'h0, e_sst});
            chk("m0_ready",    {63'h0, i_m0.ready},  {63'h0, e_rdy[0]});
            chk("m0_rdata",    i_m0.rdata,           e_rd[0]);
            chk("m1_ready",    {63'h0, i_m1.ready},  {63'h0, e_rdy[1]});
            chk("m1_rdata",    i_m1.rdata,           e_rd[1]);
            chk("timeout_err", {63'h0, timeout_err}, {63'h0, e_to});
            // State update for the coming rising edge
            if (reset) begin
                mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 1; mdl_age = 0;
            end else if (mdl_busy) begin
                if (fin) begin
                    mdl_busy = 1'b0; mdl_last = g; mdl_age = 0;
                end else begin
                    mdl_age++;
                end
            end else if (mv[0] || mv[1]) begin
                mdl_busy  = 1'b1;
                mdl_age   = 0;
                mdl_owner = (mv[0] && mv[1]) ? 1 - mdl_last : (mv[0] ? 0 : 1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        i_m0.valid = 1'b0; i_m0.addr = 64'h0; i_m0.wdata = 64'h0; i_m0.store_type = 3'd0;
        i_m1.valid = 1'b0; i_m1.addr = 64'h0; i_m1.wdata = 64'h0; i_m1.store_type = 3'd0;
        i_s.ready  = 1'b0; i_s.rdata = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        mon_en = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int   order [4];
    int   n_gr;
    logic r0, r1;

    initial begin
        reset = 1'b1;
        clear_inputs();
        do_reset();

        // Reset state
        mid();
        chk("rst_busy",  {63'h0, busy},       64'h0);
        chk("rst_grant", {63'h0, grant},      64'h0);
        chk("rst_sval",  {63'h0, i_s.valid},  64'h0);
        chk("rst_m0rdy", {63'h0, i_m0.ready}, 64'h0);

        // Single read with the slave answering 2 cycles after s_valid
        cyc();
        i_m0.valid = 1'b1; i_m0.addr = 64'h1000;
        mid(); chk("rd_n_sval", {63'h0, i_s.valid}, 64'h0);
        cyc();
        mid(); chk("rd_n1_sval", {63'h0, i_s.valid}, 64'h1);
        chk("rd_n1_addr", i_s.addr, 64'h1000);
        cyc();
        cyc();
        i_s.ready = 1'b1; i_s.rdata = 64'h1234;
        mid(); chk("rd_rdy", {63'h0, i_m0.ready}, 64'h1);
        chk("rd_data", i_m0.rdata, 64'h1234);
        cyc();
        i_m0.valid = 1'b0; i_s.ready = 1'b0;
        mid(); chk("rd_busy_fall", {63'h0, busy}, 64'h0);

        // Tie after reset, fairness order and store gating
        do_reset();
        i_m0.valid = 1'b1; i_m0.addr = 64'hA0; i_m0.store_type = 3'd0;
        i_m1.valid = 1'b1; i_m1.addr = 64'hA1; i_m1.store_type = 3'd3;
        i_s.ready  = 1'b1; i_s.rdata = 64'h77;
        n_gr = 0;
        for (int k = 0; k < 10; k++) begin
            mid();
            if (busy && n_gr < 4) begin
                order[n_gr] = int'(grant);
                chk("tie_store", {61'h0, i_s.store_type}, grant ? 64'd3 : 64'd0);
                n_gr++;
            end
            cyc();
        end
        chk("tie_count", 64'(n_gr), 64'd4);
        chk("tie_g0", 64'(order[0]), 64'd0);
        chk("tie_g1", 64'(order[1]), 64'd1);
        chk("tie_g2", 64'(order[2]), 64'd0);
        chk("tie_g3", 64'(order[3]), 64'd1);

        // Watchdog with a slave that never answers
        do_reset();
        i_m0.valid = 1'b1; i_m0.addr = 64'h2000;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            mid(); chk("wd_early_to", {63'h0, timeout_err}, 64'h0);
        end
        cyc();
        mid();
        chk("wd_rdy",  {63'h0, i_m0.ready},  64'h1);
        chk("wd_data", i_m0.rdata,           DEAD);
        chk("wd_err",  {63'h0, timeout_err}, 64'h1);
        cyc();
        i_m0.valid = 1'b0;
        mid(); chk("wd_idle", {63'h0, busy}, 64'h0);

        // s_ready in the final watchdog cycle wins over the timeout
        cyc();
        i_m0.valid = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        i_s.ready = 1'b1; i_s.rdata = 64'h5555;
        mid();
        chk("wd_win_rdy",  {63'h0, i_m0.ready},  64'h1);
        chk("wd_win_data", i_m0.rdata,           64'h5555);
        chk("wd_win_err",  {63'h0, timeout_err}, 64'h0);
        cyc();
        i_m0.valid = 1'b0; i_s.ready = 1'b0;

        // Abandon in the second BUSY cycle
        cyc();
        i_m0.valid = 1'b1; i_m0.store_type = 3'd5;
        cyc();
        mid(); chk("ab_busy", {63'h0, busy}, 64'h1);
        cyc();
        i_m0.valid = 1'b0;
        mid();
        chk("ab_sval",  {63'h0, i_s.valid},      64'h0);
        chk("ab_store", {61'h0, i_s.store_type}, 64'h0);
        chk("ab_rdy",   {63'h0, i_m0.ready},     64'h0);
        cyc();
        mid(); chk("ab_idle", {63'h0, busy}, 64'h0);

        // Reset while BUSY
        cyc();
        i_m0.valid = 1'b1; i_m0.store_type = 3'd0;
        cyc();
        reset = 1'b1;
        mid(); chk("rb_busy", {63'h0, busy}, 64'h1);
        cyc();
        reset = 1'b0; i_m0.valid = 1'b0;
        mid();
        chk("rb_busy0", {63'h0, busy},        64'h0);
        chk("rb_sval",  {63'h0, i_s.valid},   64'h0);
        chk("rb_rdy",   {63'h0, i_m0.ready},  64'h0);
        chk("rb_to",    {63'h0, timeout_err}, 64'h0);

        // Randomized traffic with a model check every cycle
        for (int c = 0; c < 4000; c++) begin
            mid();
            r0 = i_m0.ready;
            r1 = i_m1.ready;
            cyc();
            reset = ($urandom_range(499) == 0);
            if (r0 || !i_m0.valid) begin
                i_m0.valid      = ($urandom_range(2) != 0);
                i_m0.addr       = {$urandom, $urandom};
                i_m0.wdata      = {$urandom, $urandom};
                i_m0.store_type = $urandom_range(1) ? 3'($urandom_range(7)) : 3'd0;
            end else if ($urandom_range(19) == 0) begin
                i_m0.valid = 1'b0;
            end
            if (r1 || !i_m1.valid) begin
                i_m1.valid      = ($urandom_range(2) != 0);
                i_m1.addr       = {$urandom, $urandom};
                i_m1.wdata      = {$urandom, $urandom};
                i_m1.store_type = $urandom_range(1) ? 3'($urandom_range(7)) : 3'd0;
            end else if ($urandom_range(19) == 0) begin
                i_m1.valid = 1'b0;
            end
            i_s.ready = ($urandom_range(4) < 2);
            i_s.rdata = {$urandom, $urandom};
        end
        mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
